// File: rtl/approx_wallace_tree_accumulator_if.sv
// Beat-in / result-out bundle for approx_wallace_tree_accumulator.
// master = upstream producer + result consumer, slave = accumulator.
interface approx_wallace_tree_accumulator_if #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int CNT_W  = 8
);
  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] sum_vec;
  logic [PROD_W-1:0] carry_vec;
  logic              in_last;
  logic              acc_valid;
  logic              acc_ready;
  logic [ACC_W-1:0]  acc_out;
  logic [CNT_W-1:0]  acc_count;
  logic              overflow;

  modport master (
    output clear, in_valid, sum_vec, carry_vec, in_last, acc_ready,
    input  in_ready, acc_valid, acc_out, acc_count, overflow
  );

  modport slave (
    input  clear, in_valid, sum_vec, carry_vec, in_last, acc_ready,
    output in_ready, acc_valid, acc_out, acc_count, overflow
  );
endinterface

// File: rtl/approx_wallace_tree_accumulator.sv
// Resolves redundant sum/carry with a lower-part-OR adder and accumulates beats.
// Optional macro ACC_SATURATE_EN: clamp the accumulator on carry-out instead of wrapping.
//
// state | meaning
// ACCUM | accepting beats, stage 1 feeding the accumulator
// FLUSH | last beat sits in stage 1, draining into acc
// HOLD  | total complete; acc_valid raised next cycle, held until taken
module approx_wallace_tree_accumulator #(
  parameter int PROD_W      = 16,
  parameter int ACC_W       = 24,
  parameter int CNT_W       = 8,
  parameter int APPROX_LSBS = 4
) (
  input logic clk,
  input logic rst_n,
  approx_wallace_tree_accumulator_if.slave bus
);
  localparam int L = APPROX_LSBS;

  typedef enum logic [1:0] {ACCUM, FLUSH, HOLD} state_t;

  state_t            state;
  logic              s1_valid;
  logic [PROD_W:0]   s1_p;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt;
  logic              ovf;
  logic              acc_valid_q;

  logic              beat_acc;
  logic [PROD_W:0]   p_next;
  logic [ACC_W:0]    acc_sum;
  logic [CNT_W-1:0]  cnt_next;

  assign bus.in_ready  = !bus.clear && (state == ACCUM);
  assign beat_acc      = bus.in_valid && bus.in_ready;
  assign bus.acc_valid = acc_valid_q;
  assign bus.acc_out   = acc;
  assign bus.acc_count = cnt;
  assign bus.overflow  = ovf;

  // Low L bits are ORed; their would-be top carry is approximated by sum&carry of bit L-1.
  generate
    if (L == 0) begin : g_exact
      assign p_next = {1'b0, bus.sum_vec} + {1'b0, bus.carry_vec};
    end else begin : g_approx
      logic              cin;
      logic [PROD_W-L:0] hi;
      assign cin    = bus.sum_vec[L-1] & bus.carry_vec[L-1];
      assign hi     = {1'b0, bus.sum_vec[PROD_W-1:L]} + {1'b0, bus.carry_vec[PROD_W-1:L]}
                      + {{(PROD_W-L){1'b0}}, cin};
      assign p_next = {hi, bus.sum_vec[L-1:0] | bus.carry_vec[L-1:0]};
    end
  endgenerate

  assign acc_sum  = {1'b0, acc} + {{(ACC_W-PROD_W){1'b0}}, s1_p};
  assign cnt_next = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n || bus.clear) begin
      state       <= ACCUM;
      s1_valid    <= 1'b0;
      s1_p        <= '0;
      acc         <= '0;
      cnt         <= '0;
      ovf         <= 1'b0;
      acc_valid_q <= 1'b0;
    end else begin
      s1_valid <= beat_acc;
      if (beat_acc) s1_p <= p_next;

      if (s1_valid) begin
        cnt <= cnt_next;
`ifdef ACC_SATURATE_EN
        if (ovf || acc_sum[ACC_W]) begin
          acc <= {ACC_W{1'b1}};
          ovf <= 1'b1;
        end else begin
          acc <= acc_sum[ACC_W-1:0];
        end
`else
        acc <= acc_sum[ACC_W-1:0];
        ovf <= ovf | acc_sum[ACC_W];
`endif
      end

      case (state)
        ACCUM: if (beat_acc && bus.in_last) state <= FLUSH;
        FLUSH: state <= HOLD;
        HOLD: begin
          if (!acc_valid_q) begin
            acc_valid_q <= 1'b1;
          end else if (bus.acc_ready) begin
            acc_valid_q <= 1'b0;
            acc         <= '0;
            cnt         <= '0;
            ovf         <= 1'b0;
            state       <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end
endmodule

// File: tb/tb_approx_wallace_tree_accumulator.sv
// Directed bench for approx_wallace_tree_accumulator (PROD_W=16, ACC_W=24, CNT_W=8, L=4).
module tb_approx_wallace_tree_accumulator;
  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  approx_wallace_tree_accumulator_if #(.PROD_W(16), .ACC_W(24), .CNT_W(8)) bus ();

  approx_wallace_tree_accumulator #(
    .PROD_W(16), .ACC_W(24), .CNT_W(8), .APPROX_LSBS(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  typedef struct {
    logic [15:0] s;
    logic [15:0] c;
    logic        last;
    logic [23:0] exp_out;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Offers one beat and returns 1 ns after the edge that accepted it.
  task automatic send_beat(input logic [15:0] s, input logic [15:0] c, input logic last);
    int n = 0;
    bus.in_valid  = 1'b1;
    bus.sum_vec   = s;
    bus.carry_vec = c;
    bus.in_last   = last;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) chk("beat_accept_timeout", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_result(input string name, input logic [23:0] eo,
                             input logic [7:0] ec, input logic eov);
    int n = 0;
    @(negedge clk);
    while (!bus.acc_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_valid"}, 32'(bus.acc_valid), 32'd1);
    chk({name, "_out"},   32'(bus.acc_out),   32'(eo));
    chk({name, "_count"}, 32'(bus.acc_count), 32'(ec));
    chk({name, "_ovf"},   32'(bus.overflow),  32'(eov));
    bus.acc_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.acc_ready = 1'b0;
    chk({name, "_released"}, 32'(bus.acc_valid), 32'd0);
  endtask

  initial begin
    // P = {sum_hi + carry_hi + (s[3]&c[3]), s[3:0]|c[3:0]}
    vecs[0] = '{16'h0100, 16'h0020, 1'b1, 24'h000120, 8'd1};
    vecs[1] = '{16'h0003, 16'h0001, 1'b0, 24'h0,      8'd0};   // P=0x03
    vecs[2] = '{16'h000F, 16'h0008, 1'b1, 24'h000022, 8'd2};   // P=0x1F
    vecs[3] = '{16'h0008, 16'h0008, 1'b1, 24'h000018, 8'd1};   // cin from bit 3
    vecs[4] = '{16'h1234, 16'h0001, 1'b1, 24'h001235, 8'd1};
    vecs[5] = '{16'hFFFF, 16'h0001, 1'b1, 24'h00FFFF, 8'd1};   // OR hides the carry
    vecs[6] = '{16'h8000, 16'h8000, 1'b1, 24'h010000, 8'd1};   // P bit 16
    vecs[7] = '{16'h0007, 16'h0009, 1'b0, 24'h0,      8'd0};   // P=0x0F
    vecs[8] = '{16'h0010, 16'h0010, 1'b1, 24'h00002F, 8'd2};   // P=0x20

    rst_n = 1'b0;
    bus.clear = 1'b0; bus.in_valid = 1'b0; bus.in_last = 1'b0;
    bus.sum_vec = '0; bus.carry_vec = '0; bus.acc_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_acc_valid", 32'(bus.acc_valid), 32'd0);
    chk("rst_acc_out",   32'(bus.acc_out),   32'd0);
    chk("rst_acc_count", 32'(bus.acc_count), 32'd0);
    chk("rst_overflow",  32'(bus.overflow),  32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    @(posedge clk); #1;

    // Latency: accept at T, acc_valid visible only after T+2
    send_beat(16'h0100, 16'h0020, 1'b1);
    chk("lat_t0", 32'(bus.acc_valid), 32'd0);
    chk("lat_t0_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    chk("lat_t1", 32'(bus.acc_valid), 32'd0);
    @(posedge clk); #1;
    chk("lat_t2", 32'(bus.acc_valid), 32'd1);
    wait_result("lat", 24'h000120, 8'd1, 1'b0);

    for (int i = 0; i < 9; i++) begin
      send_beat(vecs[i].s, vecs[i].c, vecs[i].last);
      if (vecs[i].last) wait_result($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_cnt, 1'b0);
    end

    // 129 * 0x1FFFF = 0x101FF7F -> wraps to 0x01FF7F
    for (int i = 0; i < 129; i++) send_beat(16'hFFFF, 16'hFFFF, i == 128);
`ifdef ACC_SATURATE_EN
    wait_result("ovf", 24'hFFFFFF, 8'd129, 1'b1);
`else
    wait_result("ovf", 24'h01FF7F, 8'd129, 1'b1);
`endif

    // Count saturates at 0xFF while the sum keeps growing
    for (int i = 0; i < 260; i++) send_beat(16'h0001, 16'h0000, i == 259);
    wait_result("cnt_sat", 24'h000104, 8'hFF, 1'b0);

    // Backpressure: pending result with a beat offered for 5 cycles
    send_beat(16'h0100, 16'h0020, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    bus.in_valid = 1'b1; bus.sum_vec = 16'h0002; bus.carry_vec = 16'h0001; bus.in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_ready", i), 32'(bus.in_ready),  32'd0);
      chk($sformatf("bp%0d_valid", i), 32'(bus.acc_valid), 32'd1);
      chk($sformatf("bp%0d_out", i),   32'(bus.acc_out),   32'h000120);
      chk($sformatf("bp%0d_cnt", i),   32'(bus.acc_count), 32'd1);
    end
    wait_result("bp", 24'h000120, 8'd1, 1'b0);
    send_beat(16'h0002, 16'h0001, 1'b1);
    wait_result("bp_next", 24'h000003, 8'd1, 1'b0);

    // clear mid-accumulation drops partial sum and the beat offered with it
    for (int i = 0; i < 3; i++) send_beat(16'h0010, 16'h0000, 1'b0);
    bus.clear = 1'b1;
    bus.in_valid = 1'b1; bus.sum_vec = 16'h0040; bus.carry_vec = 16'h0000; bus.in_last = 1'b1;
    @(negedge clk);
    chk("clr_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    bus.clear = 1'b0; bus.in_valid = 1'b0; bus.in_last = 1'b0;
    @(negedge clk);
    chk("clr_acc_out", 32'(bus.acc_out),   32'd0);
    chk("clr_count",   32'(bus.acc_count), 32'd0);
    chk("clr_ready",   32'(bus.in_ready),  32'd1);
    @(posedge clk); #1;
    send_beat(16'h0005, 16'h0000, 1'b1);
    wait_result("clr", 24'h000005, 8'd1, 1'b0);

    // Reset while HOLD discards the pending result
    send_beat(16'h00F0, 16'h0000, 1'b1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("hrst_valid", 32'(bus.acc_valid), 32'd0);
    chk("hrst_out",   32'(bus.acc_out),   32'd0);
    chk("hrst_cnt",   32'(bus.acc_count), 32'd0);
    chk("hrst_ovf",   32'(bus.overflow),  32'd0);
    chk("hrst_ready", 32'(bus.in_ready),  32'd1);
    repeat (3) @(negedge clk);
    chk("hrst_no_out", 32'(bus.acc_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
